sw_timer_ctrl: RTL
==================

SW_TIMER_CTRL -- requirements
Module: sw_timer_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 100, clk cycles per centisecond tick (legal range 2..65535).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port state, input, state_t, the stopwatch mode from the mode FSM (IDLE, RUNNING, CLEAR).
REQ-005 The block SHALL have port lap, input, 1, a debounced single-cycle lap request pulse.
REQ-006 The block SHALL have port disp, output, 24, packed BCD MM:SS:CC, digits [23:20] min tens down to [3:0] cs ones.
REQ-007 The block SHALL have port tick, output, 1, a one-cycle centisecond strobe.
REQ-008 The block SHALL have port lap_hold, output, 1, high while disp shows the frozen lap value.
REQ-009 The block SHALL have port ovf, output, 1, sticky overflow flag.

Function
REQ-010 The block SHALL keep a prescaler counting 0..CLK_DIV-1, incrementing only while state==RUNNING and wrapping to 0 after CLK_DIV-1.
REQ-011 The block SHALL drive tick combinationally high iff state==RUNNING and prescaler==CLK_DIV-1.
REQ-012 The block SHALL hold the prescaler and time value unchanged in IDLE (pause); resuming continues from the held prescaler count.
REQ-013 The block SHALL, in CLEAR, zero the prescaler, time, lap register, lap_hold and ovf on the next edge, and hold them at zero while CLEAR persists.
REQ-014 The block SHALL increment time by one centisecond on each edge where tick is high; new value visible the cycle after tick.
REQ-015 The block SHALL carry CC 99->00 into seconds, SS 59->00 into minutes; each digit always a legal BCD value.
REQ-016 The block SHALL, on a tick at 59:59:99, leave time at 59:59:99 (saturate) and set ovf; ovf stays set until CLEAR or rst.
REQ-017 The block SHALL, on lap while RUNNING and lap_hold==0, capture the current pre-increment time into the lap register and set lap_hold.
REQ-018 The block SHALL, on lap while RUNNING and lap_hold==1, clear lap_hold; the lap register keeps its last value.
REQ-019 The block SHALL ignore lap in IDLE and CLEAR.
REQ-020 The block SHALL keep counting time internally while lap_hold==1.
REQ-021 The block SHALL drive disp = lap register when lap_hold==1, else the live time.
REQ-022 The block SHALL give lap and tick in the same cycle both effects: lap captures the pre-increment value, time increments.
REQ-023 The block SHALL treat an unencoded state value as IDLE (hold).

Reset
REQ-024 The block SHALL, while rst==1 at a clock edge, set prescaler, time, lap register, lap_hold and ovf to 0, overriding state and lap.
REQ-025 The block SHALL, after reset, output disp=24'h000000, lap_hold=0, ovf=0, and tick=0 until RUNNING reaches CLK_DIV-1.
REQ-026 The block SHALL, on rst asserted mid-count or mid-lap, discard all progress; the first tick comes CLK_DIV RUNNING cycles after release.

Structure
REQ-027 The block SHALL take state_t {IDLE, RUNNING, CLEAR} from the shared package sw_pkg, which also holds the BCD digit limits (9, 5) as constants.
REQ-028 The block SHALL implement each time digit with one sub-module bcd_digit (parameterized max value, inputs inc/clr, outputs 4-bit value and carry), instantiated six times.

Verification (CLK_DIV=4)
REQ-029 The bench SHALL cover reset: rst=1 for 2 cycles with state=RUNNING -> disp=0, tick=0, ovf=0, lap_hold=0; first tick on the 4th RUNNING cycle after release.
REQ-030 The bench SHALL cover counting and carry: RUNNING 40 cycles -> disp=24'h000010; run to 00:00:99, one more tick -> 24'h000100; from 00:59:99 -> 24'h010000.
REQ-031 The bench SHALL cover pause: IDLE at prescaler=2 for 10 cycles -> disp and tick frozen; back to RUNNING -> tick after exactly 2 cycles.
REQ-032 The bench SHALL cover lap: lap at 24'h000005 -> disp stays 24'h000005, lap_hold=1 for 20 cycles; second lap -> disp shows live 24'h000010.
REQ-033 The bench SHALL cover lap/tick coincidence and CLEAR: lap on a tick cycle at 00:00:07 -> lap=24'h000007, live=24'h000008; CLEAR -> all outputs 0 next cycle.
REQ-034 The bench SHALL cover overflow: run to 59:59:99, one more tick -> disp=24'h595999, ovf=1 held; CLEAR -> ovf=0.

Source files
------------

// File: rtl/sw_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sw_pkg
//  Description : Shared stopwatch definitions. Holds the mode encoding driven
//                by the mode FSM and the BCD digit rollover limits.
//  Revision    : 1.0  initial release
// ============================================================================
package sw_pkg;

    // Stopwatch mode. The fourth code (2'd3) is unused and is handled as a hold.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        CLEAR   = 2'd2
    } state_t;

    // Highest legal value of a decimal digit and of a base-6 (tens of 60) digit.
    localparam logic [3:0] c_bcd_limit_9 = 4'd9;
    localparam logic [3:0] c_bcd_limit_5 = 4'd5;

endpackage
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit
//  Description : One BCD time digit counting 0..MAX_VAL. Rolls over to 0 on an
//                increment at MAX_VAL and reports that rollover as carry.
//  Ports       : clk   - system clock
//                rst   - synchronous active-high reset
//                inc   - advance the digit by one on this edge
//                clr   - synchronous clear to zero
//                value - current digit value
//                carry - combinational, high when inc rolls the digit over
//  Revision    : 1.0  initial release
// ============================================================================
module bcd_digit #(
    parameter logic [3:0] MAX_VAL = 4'd9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] value,
    output logic       carry
);

    logic [3:0] r_value;
    logic       w_at_max;

    assign w_at_max = (r_value == MAX_VAL);
    assign carry    = inc && w_at_max;
    assign value    = r_value;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_value <= 4'd0;
        end else if (inc) begin
            r_value <= w_at_max ? 4'd0 : r_value + 4'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sw_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sw_timer_ctrl
//  Description : Stopwatch time base. Divides clk down to a centisecond tick,
//                keeps an MM:SS:CC BCD time that saturates at 59:59:99, and
//                supports a lap freeze of the displayed value.
//  Ports       : clk      - system clock, rising edge
//                rst      - synchronous active-high reset
//                state    - stopwatch mode (IDLE / RUNNING / CLEAR)
//                lap      - single-cycle lap request
//                disp     - BCD MM:SS:CC, [23:20] min tens .. [3:0] cs ones
//                tick     - one-cycle centisecond strobe
//                lap_hold - disp is showing the frozen lap value
//                ovf      - sticky overflow flag
//  Revision    : 1.0  initial release
// ============================================================================
module sw_timer_ctrl
    import sw_pkg::*;
#(
    parameter int CLK_DIV = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  state_t      state,
    input  logic        lap,
    output logic [23:0] disp,
    output logic        tick,
    output logic        lap_hold,
    output logic        ovf
);

    localparam logic [15:0] c_presc_last = 16'(CLK_DIV - 1);
    localparam logic [23:0] c_time_max   = 24'h595999;
    localparam int          c_num_digits = 6;

    logic [15:0] r_presc;
    logic [23:0] r_lap;
    logic        r_lap_hold;
    logic        r_ovf;

    logic        w_run;
    logic        w_clr;
    logic        w_tick;
    logic        w_at_max;
    logic [23:0] w_time;
    // Ripple increment chain: w_carry[0] advances the cs ones digit and each
    // digit's rollover advances the next one up.
    logic [c_num_digits:0] w_carry;

    // Any code other than RUNNING or CLEAR (including the unused one) holds.
    assign w_run    = (state == RUNNING);
    assign w_clr    = (state == CLEAR);
    assign w_tick   = w_run && (r_presc == c_presc_last);
    assign w_at_max = (w_time == c_time_max);

    // Suppressing the increment at 59:59:99 is what makes the time saturate.
    assign w_carry[0] = w_tick && !w_at_max;

    genvar gi;
    generate
        for (gi = 0; gi < c_num_digits; gi++) begin : g_digit
            // Digits 3 (sec tens) and 5 (min tens) count base 6.
            localparam logic [3:0] c_max = ((gi == 3) || (gi == 5)) ? c_bcd_limit_5
                                                                    : c_bcd_limit_9;
            bcd_digit #(
                .MAX_VAL (c_max)
            ) u_digit (
                .clk   (clk),
                .rst   (rst),
                .inc   (w_carry[gi]),
                .clr   (w_clr),
                .value (w_time[4*gi +: 4]),
                .carry (w_carry[gi+1])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || w_clr) begin
            r_presc    <= 16'd0;
            r_lap      <= 24'd0;
            r_lap_hold <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_run) begin
            r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;

            // Lap toggles the freeze; the capture takes the pre-increment
            // time even when a tick lands on the same edge.
            if (lap) begin
                if (!r_lap_hold) begin
                    r_lap      <= w_time;
                    r_lap_hold <= 1'b1;
                end else begin
                    r_lap_hold <= 1'b0;
                end
            end

            // A carry out of the minutes-tens digit cannot occur while the
            // saturation guard is in place, but would also be an overflow.
            if ((w_tick && w_at_max) || w_carry[c_num_digits]) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign tick     = w_tick;
    assign disp     = r_lap_hold ? r_lap : w_time;
    assign lap_hold = r_lap_hold;
    assign ovf      = r_ovf;

endmodule
`default_nettype wire
